iq_ready_tracker: RTL and testbench
===================================

// Module: iq_ready_tracker
// PURPOSE
// - Per-entry operand-ready/valid state for the issue queue, downstream of the two wakeup CAMs (src1, src2).
// - Folds per-broadcast-port CAM match vectors into sticky ready bits, loads state at dispatch, frees on grant/flush.
// - Drives the registered-state request vector to select logic and an occupancy count.
// PARAMETERS
// - DEPTH      32  issue-queue entries
// - INDEX      5   log2(DEPTH)
// - ISSUE_W    4   wakeup broadcast ports (one per issue lane)
// - DISPATCH_W 4   dispatch write ports
// PORTS
// - clk            in  1                  clock, rising edge
// - reset          in  1                  asynchronous, active-low; 0 = reset
// - tagValid_i     in  ISSUE_W            broadcast port p carries a real tag this cycle
// - src1Vect_i     in  ISSUE_W x DEPTH    src1 wakeup-CAM match vectors, one per port
// - src2Vect_i     in  ISSUE_W x DEPTH    src2 wakeup-CAM match vectors, one per port
// - dispValid_i    in  DISPATCH_W         dispatch lane d writes an entry
// - dispAddr_i     in  DISPATCH_W x INDEX entry index for lane d
// - dispSrc1Rdy_i  in  DISPATCH_W         src1 ready at dispatch (incl. same-cycle bypass)
// - dispSrc2Rdy_i  in  DISPATCH_W         src2 ready at dispatch
// - grantVect_i    in  DEPTH              entries issued this cycle (from select)
// - flush_i        in  1                  squash all entries
// - reqVect_o      out DEPTH              valid & src1Rdy & src2Rdy, per entry
// - occupancy_o    out INDEX+1            number of valid entries, 0..DEPTH
// BEHAVIOUR
// - State per entry: valid, rdy1, rdy2 (flops, async reset to 0). Reset: reqVect_o=0, occupancy_o=0.
// - reqVect_o is combinational from state flops only: a wakeup at edge N raises the request in cycle N+1.
// - Wakeup: hit1[e] = OR over p of (tagValid_i[p] & src1Vect_i[p][e]); same for hit2. CAM vectors without tagValid are ignored.
// - Wakeup applies only to entries valid before the edge: rdy1 <= rdy1 | (valid & hit1). Ready bits are sticky until freed.
// - Dispatch lane d (dispValid_i[d]): valid<=1, rdy1<=dispSrc1Rdy_i[d], rdy2<=dispSrc2Rdy_i[d]. It overrides any same-cycle wakeup hit on that entry (CAM content is stale for it).
// - Grant: grantVect_i[e] -> valid, rdy1, rdy2 <= 0 next cycle.
// - Priority per entry, highest first: flush_i > dispatch > grant > wakeup.
// - flush_i: all valid/rdy cleared and occupancy_o <= 0, regardless of same-cycle dispatch or grant.
// - Occupancy: occ <= occ + popcount(dispatches to non-valid entries) - popcount(grants to valid entries not re-dispatched).
//   - Computed at INDEX+2 bits, stored at INDEX+1. Never wraps.
// - Errors, asserted in simulation, not handled in RTL:
//   - two dispatch lanes with the same address
//   - dispatch to a valid entry
//   - grant of a non-valid or non-requesting entry
//   - occupancy > DEPTH
// - Grants and dispatches of an entry in the same cycle are legal only if the entry is reallocated after issue; dispatch wins.
// - Reset mid-operation: all state clears immediately (async); the first edge after deassertion accepts dispatch.
// STRUCTURE
// - iq_pkg: DEPTH/INDEX/ISSUE_W/DISPATCH_W constants, typedef iq_idx_t, typedef struct {valid,rdy1,rdy2} iq_rdy_t.
// - Sub-module iq_ready_entry (one per entry, generate loop):
//   - inputs: hit1, hit2, dispatch-select one-hot, grant, flush
//   - outputs: valid, req
// - Top level: per-port OR reduction, dispatch address decode (DISPATCH_W one-hots), popcounts, occupancy counter.
// TESTING
// - Reset: hold reset=0 3 cycles -> reqVect_o=0, occupancy_o=0; after release, no request without dispatch.
// - Dispatch entry 5 with rdy1=1, rdy2=0; cycle later tagValid[2]=1 with src2Vect[2][5]=1 -> reqVect_o[5]=1 next cycle; occupancy_o=1.
// - Same cycle: dispatch entry 7 (rdy 0/0) and src1Vect[0][7]=1 with tagValid[0]=1 -> entry 7 rdy1 stays 0.
// - Match with tagValid[1]=0 on a valid entry -> no ready change.
// - Fill all 32 entries fully ready -> occupancy_o=32, reqVect_o=all ones.
//   - Then grant 0xFFFF_FFFF -> occupancy_o=0, reqVect_o=0.
// - With 10 valid: flush_i=1 plus dispatch of 2 lanes -> occupancy_o=0, reqVect_o=0.
//   - Assert reset mid-wakeup -> state zero immediately.

Source files
------------

// File: rtl/iq_pkg.sv
// Shared sizing constants and per-entry state type for the issue-queue
// ready tracker.
package iq_pkg;
  localparam int DEPTH      = 32;
  localparam int INDEX      = 5;
  localparam int ISSUE_W    = 4;
  localparam int DISPATCH_W = 4;

  typedef logic [INDEX-1:0] iq_idx_t;
  typedef logic [INDEX:0]   iq_cnt_t;

  typedef struct packed {
    logic valid;
    logic rdy1;
    logic rdy2;
  } iq_rdy_t;
endpackage

// File: rtl/iq_ready_entry.sv
// One issue-queue entry: valid plus two sticky operand-ready bits.
// Update priority is flush, then dispatch, then grant, then wakeup.
module iq_ready_entry
  import iq_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hit1_i,
  input  logic                  hit2_i,
  input  logic [DISPATCH_W-1:0] dispSel_i,
  input  logic [DISPATCH_W-1:0] dispSrc1Rdy_i,
  input  logic [DISPATCH_W-1:0] dispSrc2Rdy_i,
  input  logic                  grant_i,
  input  logic                  flush_i,
  output logic                  valid_o,
  output logic                  req_o
);

  iq_rdy_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = '0;
    end else if (|dispSel_i) begin
      // Dispatch ignores same-cycle wakeup: the CAM still holds the old tags.
      state_d.valid = 1'b1;
      state_d.rdy1  = |(dispSel_i & dispSrc1Rdy_i);
      state_d.rdy2  = |(dispSel_i & dispSrc2Rdy_i);
    end else if (grant_i) begin
      state_d = '0;
    end else if (state_q.valid) begin
      state_d.rdy1 = state_q.rdy1 | hit1_i;
      state_d.rdy2 = state_q.rdy2 | hit2_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= '0;
    else        state_q <= state_d;
  end

  assign valid_o = state_q.valid;
  assign req_o   = state_q.valid & state_q.rdy1 & state_q.rdy2;

endmodule

// File: rtl/iq_ready_tracker.sv
// Issue-queue operand-ready tracker: folds wakeup CAM matches into per-entry
// ready state, handles dispatch/grant/flush and keeps an occupancy count.
module iq_ready_tracker
  import iq_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ISSUE_W-1:0]          tagValid_i,
  input  logic [ISSUE_W*DEPTH-1:0]    src1Vect_i,
  input  logic [ISSUE_W*DEPTH-1:0]    src2Vect_i,
  input  logic [DISPATCH_W-1:0]       dispValid_i,
  input  logic [DISPATCH_W*INDEX-1:0] dispAddr_i,
  input  logic [DISPATCH_W-1:0]       dispSrc1Rdy_i,
  input  logic [DISPATCH_W-1:0]       dispSrc2Rdy_i,
  input  logic [DEPTH-1:0]            grantVect_i,
  input  logic                        flush_i,
  output logic [DEPTH-1:0]            reqVect_o,
  output logic [INDEX:0]              occupancy_o
);

  logic [DEPTH-1:0]                 hit1, hit2;
  logic [DEPTH-1:0][DISPATCH_W-1:0] dispSel;
  logic [DEPTH-1:0]                 dispAny;
  logic [DEPTH-1:0]                 valid;
  logic [INDEX+1:0]                 nDisp, nGrant, occSum;
  iq_cnt_t                          occ_q, occ_d;

  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      if (tagValid_i[p]) begin
        hit1 = hit1 | src1Vect_i[p*DEPTH +: DEPTH];
        hit2 = hit2 | src2Vect_i[p*DEPTH +: DEPTH];
      end
    end
  end

  always_comb begin
    dispSel = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int d = 0; d < DISPATCH_W; d++) begin
        dispSel[e][d] = dispValid_i[d] && (dispAddr_i[d*INDEX +: INDEX] == iq_idx_t'(e));
      end
      dispAny[e] = |dispSel[e];
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    iq_ready_entry u_entry (
      .clk           (clk),
      .reset         (reset),
      .hit1_i        (hit1[e]),
      .hit2_i        (hit2[e]),
      .dispSel_i     (dispSel[e]),
      .dispSrc1Rdy_i (dispSrc1Rdy_i),
      .dispSrc2Rdy_i (dispSrc2Rdy_i),
      .grant_i       (grantVect_i[e]),
      .flush_i       (flush_i),
      .valid_o       (valid[e]),
      .req_o         (reqVect_o[e])
    );
  end

  // A grant on an entry re-dispatched in the same cycle is not a release.
  always_comb begin
    nDisp  = '0;
    nGrant = '0;
    for (int e = 0; e < DEPTH; e++) begin
      nDisp  = nDisp  + (INDEX+2)'(dispAny[e] & ~valid[e]);
      nGrant = nGrant + (INDEX+2)'(grantVect_i[e] & valid[e] & ~dispAny[e]);
    end
    occSum = (INDEX+2)'(occ_q) + nDisp - nGrant;
    occ_d  = flush_i ? '0 : iq_cnt_t'(occSum);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign occupancy_o = occ_q;

`ifndef SYNTHESIS
  logic errDupAddr, errDispValid, errGrant, errOcc;

  always_comb begin
    errDupAddr = 1'b0;
    for (int i = 0; i < DISPATCH_W; i++) begin
      for (int j = i + 1; j < DISPATCH_W; j++) begin
        if (dispValid_i[i] && dispValid_i[j] &&
            dispAddr_i[i*INDEX +: INDEX] == dispAddr_i[j*INDEX +: INDEX])
          errDupAddr = 1'b1;
      end
    end
    errDispValid = |(dispAny & valid & ~grantVect_i);
    errGrant     = |(grantVect_i & ~reqVect_o);
    errOcc       = (occ_q > iq_cnt_t'(DEPTH));
  end

  a_dup_addr:   assert property (@(posedge clk) disable iff (!reset) !errDupAddr)
    else $error("iq_ready_tracker: two dispatch lanes share an address");
  a_disp_valid: assert property (@(posedge clk) disable iff (!reset) !errDispValid)
    else $error("iq_ready_tracker: dispatch to a valid entry");
  a_grant:      assert property (@(posedge clk) disable iff (!reset) !errGrant)
    else $error("iq_ready_tracker: grant of a non-requesting entry");
  a_occ:        assert property (@(posedge clk) disable iff (!reset) !errOcc)
    else $error("iq_ready_tracker: occupancy above depth");
`endif

endmodule

// File: tb/tb_iq_ready_tracker.sv
// Scoreboard bench for iq_ready_tracker: a behavioural model predicts the
// request vector and occupancy after every driven cycle.
module tb_iq_ready_tracker;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   tagValid;
  logic [127:0] src1Vect, src2Vect;
  logic [3:0]   dispValid;
  logic [19:0]  dispAddr;
  logic [3:0]   dS1, dS2;
  logic [31:0]  grantVect;
  logic         flush;
  logic [31:0]  reqVect;
  logic [5:0]   occ;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_valid, m_r1, m_r2;
  int          m_occ;

  typedef struct {
    string       nm;
    logic [31:0] req;
    logic [5:0]  occ;
  } exp_t;
  exp_t sb[$];

  iq_ready_tracker dut (
    .clk           (clk),
    .reset         (reset),
    .tagValid_i    (tagValid),
    .src1Vect_i    (src1Vect),
    .src2Vect_i    (src2Vect),
    .dispValid_i   (dispValid),
    .dispAddr_i    (dispAddr),
    .dispSrc1Rdy_i (dS1),
    .dispSrc2Rdy_i (dS2),
    .grantVect_i   (grantVect),
    .flush_i       (flush),
    .reqVect_o     (reqVect),
    .occupancy_o   (occ)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    tagValid = '0; src1Vect = '0; src2Vect = '0;
    dispValid = '0; dispAddr = '0; dS1 = '0; dS2 = '0;
    grantVect = '0; flush = 1'b0;
  endtask

  task automatic model_clear();
    m_valid = '0; m_r1 = '0; m_r2 = '0; m_occ = 0;
  endtask

  task automatic disp(input int lane, input int addr, input logic r1, input logic r2);
    dispValid[lane]         = 1'b1;
    dispAddr[lane*5 +: 5]   = 5'(addr);
    dS1[lane]               = r1;
    dS2[lane]               = r2;
  endtask

  task automatic model_update();
    logic [31:0] h1, h2, nv, n1, n2;
    h1 = '0; h2 = '0;
    for (int p = 0; p < 4; p++) begin
      if (tagValid[p]) begin
        h1 |= src1Vect[p*32 +: 32];
        h2 |= src2Vect[p*32 +: 32];
      end
    end
    nv = m_valid; n1 = m_r1; n2 = m_r2;
    for (int e = 0; e < 32; e++) begin
      if (grantVect[e]) begin
        nv[e] = 1'b0; n1[e] = 1'b0; n2[e] = 1'b0;
      end else if (m_valid[e]) begin
        n1[e] = m_r1[e] | h1[e];
        n2[e] = m_r2[e] | h2[e];
      end
    end
    for (int d = 0; d < 4; d++) begin
      if (dispValid[d]) begin
        nv[dispAddr[d*5 +: 5]] = 1'b1;
        n1[dispAddr[d*5 +: 5]] = dS1[d];
        n2[dispAddr[d*5 +: 5]] = dS2[d];
      end
    end
    if (flush) begin
      nv = '0; n1 = '0; n2 = '0;
    end
    m_valid = nv; m_r1 = n1; m_r2 = n2;
    m_occ = $countones(nv);
  endtask

  // Drive is already set up at a falling edge; predict, clock, compare.
  task automatic step(input string nm);
    exp_t x;
    model_update();
    x.nm  = nm;
    x.req = m_valid & m_r1 & m_r2;
    x.occ = 6'(m_occ);
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    checks++;
    if (reqVect !== x.req) begin
      errors++;
      $display("FAIL %s reqVect: got %h expected %h", x.nm, reqVect, x.req);
    end
    checks++;
    if (occ !== x.occ) begin
      errors++;
      $display("FAIL %s occupancy: got %0d expected %0d", x.nm, occ, x.occ);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (reqVect !== 32'h0) begin
      errors++; $display("FAIL reset_req: got %h expected 0", reqVect);
    end
    checks++;
    if (occ !== 6'd0) begin
      errors++; $display("FAIL reset_occ: got %0d expected 0", occ);
    end
    @(negedge clk);
    reset = 1'b1;
    step("idle_after_reset_0");
    step("idle_after_reset_1");
  endtask

  task automatic test_wakeup();
    disp(0, 5, 1'b1, 1'b0);
    step("wake5_dispatch");
    checks++;
    if (reqVect[5] !== 1'b0) begin
      errors++; $display("FAIL wake5_not_ready: got %b expected 0", reqVect[5]);
    end
    tagValid[2] = 1'b1;
    src2Vect[2*32 + 5] = 1'b1;
    step("wake5_src2");
    checks++;
    if (reqVect[5] !== 1'b1 || occ !== 6'd1) begin
      errors++;
      $display("FAIL wake5_ready: got req5=%b occ=%0d expected req5=1 occ=1", reqVect[5], occ);
    end
  endtask

  task automatic test_disp_override();
    disp(1, 7, 1'b0, 1'b0);
    tagValid[0] = 1'b1;
    src1Vect[0*32 + 7] = 1'b1;
    step("ovr7_dispatch_with_hit");
    tagValid[3] = 1'b1;
    src2Vect[3*32 + 7] = 1'b1;
    step("ovr7_src2");
    checks++;
    if (reqVect[7] !== 1'b0) begin
      errors++; $display("FAIL ovr7_rdy1_stays_low: got %b expected 0", reqVect[7]);
    end
  endtask

  task automatic test_tagvalid();
    src1Vect[1*32 + 7] = 1'b1;
    step("tv7_gated_match");
    checks++;
    if (reqVect[7] !== 1'b0) begin
      errors++; $display("FAIL tv7_no_change: got %b expected 0", reqVect[7]);
    end
    tagValid[1] = 1'b1;
    src1Vect[1*32 + 7] = 1'b1;
    step("tv7_real_match");
    checks++;
    if (reqVect !== 32'h0000_00A0 || occ !== 6'd2) begin
      errors++;
      $display("FAIL tv7_ready: got req=%h occ=%0d expected req=000000a0 occ=2", reqVect, occ);
    end
    grantVect = 32'h0000_00A0;
    step("tv_grant_5_7");
  endtask

  task automatic test_fill();
    for (int c = 0; c < 8; c++) begin
      for (int l = 0; l < 4; l++) disp(l, c*4 + l, 1'b1, 1'b1);
      step("fill");
    end
    checks++;
    if (reqVect !== 32'hFFFF_FFFF || occ !== 6'd32) begin
      errors++;
      $display("FAIL fill_full: got req=%h occ=%0d expected req=ffffffff occ=32", reqVect, occ);
    end
    grantVect = 32'hFFFF_FFFF;
    step("grant_all");
    checks++;
    if (reqVect !== 32'h0 || occ !== 6'd0) begin
      errors++;
      $display("FAIL grant_all_empty: got req=%h occ=%0d expected req=0 occ=0", reqVect, occ);
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 3; c++) begin
      for (int l = 0; l < 4; l++) begin
        if (c*4 + l < 10) disp(l, c*4 + l, 1'b1, 1'((c*4 + l) % 2));
      end
      step("flush_prefill");
    end
    checks++;
    if (occ !== 6'd10) begin
      errors++; $display("FAIL flush_prefill_occ: got %0d expected 10", occ);
    end
    flush = 1'b1;
    disp(0, 20, 1'b1, 1'b1);
    disp(1, 21, 1'b1, 1'b1);
    step("flush_with_dispatch");
    checks++;
    if (reqVect !== 32'h0 || occ !== 6'd0) begin
      errors++;
      $display("FAIL flush_clears: got req=%h occ=%0d expected req=0 occ=0", reqVect, occ);
    end
  endtask

  task automatic test_reset_mid();
    disp(0, 3, 1'b1, 1'b0);
    disp(1, 4, 1'b1, 1'b0);
    step("mid_prefill");
    tagValid[1] = 1'b1;
    src2Vect[1*32 + 3] = 1'b1;
    src2Vect[1*32 + 4] = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (reqVect !== 32'h0 || occ !== 6'd0) begin
      errors++;
      $display("FAIL reset_mid_async: got req=%h occ=%0d expected req=0 occ=0", reqVect, occ);
    end
    model_clear();
    @(posedge clk);
    #1;
    checks++;
    if (reqVect !== 32'h0 || occ !== 6'd0) begin
      errors++;
      $display("FAIL reset_mid_held: got req=%h occ=%0d expected req=0 occ=0", reqVect, occ);
    end
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    disp(0, 3, 1'b1, 1'b1);
    disp(1, 4, 1'b0, 1'b1);
    step("b2b_first_edge_dispatch");
    tagValid[0] = 1'b1;
    src1Vect[0*32 + 4] = 1'b1;
    step("b2b_wake4");
    checks++;
    if (reqVect !== 32'h0000_0018 || occ !== 6'd2) begin
      errors++;
      $display("FAIL b2b_ready: got req=%h occ=%0d expected req=00000018 occ=2", reqVect, occ);
    end
    // Issue entry 3 and reallocate it in the same cycle; dispatch wins.
    grantVect = 32'h0000_0018;
    disp(2, 3, 1'b0, 1'b1);
    step("b2b_grant_realloc");
    checks++;
    if (reqVect !== 32'h0 || occ !== 6'd1) begin
      errors++;
      $display("FAIL b2b_realloc: got req=%h occ=%0d expected req=0 occ=1", reqVect, occ);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 60; c++) begin
      int lane;
      int start;
      int e;
      grantVect = (m_valid & m_r1 & m_r2) & $urandom();
      tagValid  = 4'($urandom());
      src1Vect  = {$urandom(), $urandom(), $urandom(), $urandom()};
      src2Vect  = {$urandom(), $urandom(), $urandom(), $urandom()};
      flush     = ($urandom_range(15) == 0);
      lane  = 0;
      start = int'($urandom_range(31));
      for (int k = 0; k < 32 && lane < 4; k++) begin
        e = (start + k) % 32;
        if (!m_valid[e] && $urandom_range(1) == 1) begin
          disp(lane, e, 1'($urandom_range(1)), 1'($urandom_range(1)));
          lane++;
        end
      end
      step("random");
    end
  endtask

  initial begin
    test_reset();
    test_wakeup();
    test_disp_override();
    test_tagvalid();
    test_fill();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
